// File: rtl/sweep_capture_ctrl.sv
// Sweep capture controller: steps the MMCM through num_steps frequencies and captures
// SAMPLES FIFO results per step into BRAM, checking them against a golden ROM.
module sweep_capture_ctrl #(
  parameter int AddrWL  = 11,
  parameter int DataW   = 18,
  parameter int StepW   = 5,
  parameter int SAMPLES = 2**AddrWL,
  parameter int CLR_CYC = 8,
  parameter int TIMEOUT = 4096,
  parameter int ErrW    = AddrWL + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [StepW-1:0]  num_steps,
  input  logic              mmcm_lock,
  output logic              step_req,
  output logic              dut_en,
  output logic              fifo_clear,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DataW-1:0]  fifo_dout,
  output logic              bram_write_en,
  output logic [AddrWL-1:0] bram_address_write,
  output logic [DataW-1:0]  bram_din,
  output logic [AddrWL-1:0] gold_addr,
  input  logic [DataW-1:0]  gold_data,
  output logic              res_valid,
  output logic [StepW-1:0]  res_step,
  output logic [ErrW-1:0]   res_err_count,
  output logic [AddrWL-1:0] res_first_err,
  output logic [1:0]        res_status,
  output logic              busy,
  output logic              done
);

  // Sample counters need one extra bit so that SAMPLES == 2**AddrWL is representable.
  localparam int CntW = AddrWL + 1;
  localparam int ClrW = $clog2(CLR_CYC + 1);
  localparam int ToW  = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] SampN    = CntW'(SAMPLES);
  localparam logic [CntW-1:0] SampLast = CntW'(SAMPLES - 1);
  localparam logic [ClrW-1:0] ClrLast  = ClrW'(CLR_CYC - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT - 1);

  localparam logic [1:0] StOk      = 2'b00;
  localparam logic [1:0] StTimeout = 2'b01;
  localparam logic [1:0] StLock    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOCK_WAIT, S_RUN, S_FLUSH, S_REPORT, S_STEP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [StepW-1:0]   nsteps_q, nsteps_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [ClrW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [ToW-1:0]     idle_cnt_q, idle_cnt_d;
  logic               flush_q, flush_d;
  logic [CntW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]    wr_cnt_q, wr_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [AddrWL-1:0]  wr_addr_q, wr_addr_d;
  logic [ErrW-1:0]    err_cnt_q, err_cnt_d;
  logic [AddrWL-1:0]  first_err_q, first_err_d;
  logic               first_seen_q, first_seen_d;
  logic [1:0]         status_q, status_d;
  logic               res_valid_q, res_valid_d;
  logic [StepW-1:0]   res_step_q, res_step_d;
  logic [ErrW-1:0]    res_err_q, res_err_d;
  logic [AddrWL-1:0]  res_first_q, res_first_d;
  logic [1:0]         res_status_q, res_status_d;
  logic               step_req_q, step_req_d;
  logic               dut_en_q, dut_en_d;
  logic               fifo_clear_q, fifo_clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               rd_en;
  logic               mismatch;
  logic [StepW:0]     step_inc;

  // Reads are gated by lock so nothing new enters the pipeline in the lock-loss exit cycle.
  assign rd_en    = (state_q == S_RUN) && !fifo_empty && (rd_cnt_q < SampN) && mmcm_lock;
  assign mismatch = wr_en_q && (fifo_dout != gold_data);
  assign step_inc = {1'b0, step_q} + (StepW + 1)'(1);

  always_comb begin
    state_d      = state_q;
    nsteps_d     = nsteps_q;
    step_d       = step_q;
    clr_cnt_d    = clr_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    flush_d      = flush_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
    first_seen_d = first_seen_q;
    status_d     = status_q;
    res_step_d   = res_step_q;
    res_err_d    = res_err_q;
    res_first_d  = res_first_q;
    res_status_d = res_status_q;
    res_valid_d  = 1'b0;
    step_req_d   = 1'b0;
    done_d       = 1'b0;

    // Write/compare stage runs regardless of state so aborted steps still retire their reads.
    wr_en_d   = rd_en;
    wr_addr_d = rd_en ? rd_cnt_q[AddrWL-1:0] : wr_addr_q;
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end
    if (wr_en_q) begin
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end
    if (mismatch) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ErrW'(1);
      end
      if (!first_seen_q) begin
        first_seen_d = 1'b1;
        first_err_d  = wr_addr_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nsteps_d  = (num_steps == '0) ? StepW'(1) : num_steps;
          step_d    = '0;
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rd_cnt_d     = '0;
        wr_cnt_d     = '0;
        err_cnt_d    = '0;
        first_err_d  = '0;
        first_seen_d = 1'b0;
        if (clr_cnt_q == ClrLast) begin
          state_d = S_LOCK_WAIT;
        end else begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
      end
      S_LOCK_WAIT: begin
        idle_cnt_d = '0;
        if (mmcm_lock) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        idle_cnt_d = rd_en ? '0 : idle_cnt_q + ToW'(1);
        flush_d    = 1'b0;
        if (wr_en_q && (wr_cnt_q == SampLast)) begin
          status_d = StOk;
          state_d  = S_FLUSH;
        end else if (!mmcm_lock) begin
          status_d = StLock;
          state_d  = S_FLUSH;
        end else if (!rd_en && (idle_cnt_q == ToLast)) begin
          status_d = StTimeout;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Second flush cycle: the last compare has landed in err_cnt_q.
        if (flush_q) begin
          res_valid_d  = 1'b1;
          res_step_d   = step_q;
          res_err_d    = err_cnt_q;
          res_first_d  = first_err_q;
          res_status_d = status_q;
          state_d      = S_REPORT;
        end else begin
          flush_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (step_inc < {1'b0, nsteps_q}) begin
          step_req_d = 1'b1;
          state_d    = S_STEP;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        if (!mmcm_lock) begin
          step_d    = step_inc[StepW-1:0];
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dut_en_d     = (state_d == S_RUN);
    fifo_clear_d = (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      nsteps_q     <= '0;
      step_q       <= '0;
      clr_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      flush_q      <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      first_seen_q <= 1'b0;
      status_q     <= '0;
      res_valid_q  <= 1'b0;
      res_step_q   <= '0;
      res_err_q    <= '0;
      res_first_q  <= '0;
      res_status_q <= '0;
      step_req_q   <= 1'b0;
      dut_en_q     <= 1'b0;
      fifo_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nsteps_q     <= nsteps_d;
      step_q       <= step_d;
      clr_cnt_q    <= clr_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      flush_q      <= flush_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      first_seen_q <= first_seen_d;
      status_q     <= status_d;
      res_valid_q  <= res_valid_d;
      res_step_q   <= res_step_d;
      res_err_q    <= res_err_d;
      res_first_q  <= res_first_d;
      res_status_q <= res_status_d;
      step_req_q   <= step_req_d;
      dut_en_q     <= dut_en_d;
      fifo_clear_q <= fifo_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign step_req           = step_req_q;
  assign dut_en             = dut_en_q;
  assign fifo_clear         = fifo_clear_q;
  assign fifo_rd_en         = rd_en;
  assign gold_addr          = rd_cnt_q[AddrWL-1:0];
  assign bram_write_en      = wr_en_q;
  assign bram_address_write = wr_addr_q;
  assign bram_din           = wr_en_q ? fifo_dout : '0;
  assign res_valid          = res_valid_q;
  assign res_step           = res_step_q;
  assign res_err_count      = res_err_q;
  assign res_first_err      = res_first_q;
  assign res_status         = res_status_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_sweep_capture_ctrl.sv
// Scoreboard bench for sweep_capture_ctrl: FIFO/ROM/MMCM models feed the DUT, expected
// BRAM writes and step reports are queued and checked by a negedge monitor.
module tb_sweep_capture_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 18;
  localparam int SW  = 5;
  localparam int NS  = 16;
  localparam int CLR = 8;
  localparam int TO  = 64;
  localparam int EW  = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          mmcm_lock = 1'b1;
  logic          step_req, dut_en, fifo_clear, fifo_rd_en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          bram_write_en;
  logic [AW-1:0] bram_address_write, gold_addr, res_first_err;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] gold_data = '0;
  logic          res_valid, busy, done;
  logic [SW-1:0] res_step;
  logic [EW-1:0] res_err_count;
  logic [1:0]    res_status;

  always #5 clk = ~clk;

  sweep_capture_ctrl #(
    .AddrWL(AW), .DataW(DW), .StepW(SW), .SAMPLES(NS),
    .CLR_CYC(CLR), .TIMEOUT(TO), .ErrW(EW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .num_steps(num_steps),
    .mmcm_lock(mmcm_lock), .step_req(step_req), .dut_en(dut_en),
    .fifo_clear(fifo_clear), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .bram_write_en(bram_write_en),
    .bram_address_write(bram_address_write), .bram_din(bram_din),
    .gold_addr(gold_addr), .gold_data(gold_data), .res_valid(res_valid),
    .res_step(res_step), .res_err_count(res_err_count),
    .res_first_err(res_first_err), .res_status(res_status),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gold_of(input int a);
    return DW'(a * 291 + 165);
  endfunction

  // Golden ROM, one cycle latency.
  always @(posedge clk) gold_data <= gold_of(int'(gold_addr));

  // Producer + standard-mode FIFO; every produced sample is also queued as an expected write.
  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int step; int err; int first; int status; } rep_t;
  wr_t           exp_wr[$];
  rep_t          exp_rep[$];
  logic [DW-1:0] fifo_q[$];
  logic [NS-1:0] corrupt_mask = '0;
  int            prod_limit = NS;
  int            prod_idx = 0;
  logic [DW-1:0] pd;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    if (fifo_clear) begin
      fifo_q.delete();
      exp_wr.delete();
      prod_idx = 0;
    end else if (dut_en && prod_idx < prod_limit) begin
      pd = gold_of(prod_idx) ^ (corrupt_mask[prod_idx] ? 18'd1 : 18'd0);
      fifo_q.push_back(pd);
      exp_wr.push_back('{prod_idx, pd});
      prod_idx++;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // MMCM model: drops lock after step_req, or after reading sample kill_at.
  int kill_at = -1;
  bit kill_active = 1'b0;
  int rd_idx = 0;
  int relock_cnt = 0;
  always @(posedge clk) begin
    if (fifo_clear) rd_idx = 0;
    else if (fifo_rd_en) begin
      if (rd_idx == kill_at) kill_active = 1'b1;
      rd_idx++;
    end
    if (kill_at < 0) kill_active = 1'b0;
    if (step_req) relock_cnt = 12;
    else if (relock_cnt > 0) relock_cnt--;
    mmcm_lock <= !kill_active && (relock_cnt == 0);
  end

  int cyc = 0, last_rd_cyc = 0, rv_cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) last_rd_cyc = cyc;
    if (res_valid) rv_cyc = cyc;
  end

  // Monitor.
  int wr_count = 0, rep_count = 0, step_cnt = 0, done_cnt = 0;
  bit lock_check_en = 1'b0, chk_dut_en_next = 1'b0, prev_lock = 1'b1;
  wr_t  w;
  rep_t r;
  always @(negedge clk) begin
    if (nrst) begin
      if (bram_write_en) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          check("write_unexpected_addr", bram_address_write, -1);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", bram_address_write, w.addr);
          check("wr_data", bram_din, w.data);
        end
      end
      if (res_valid) begin
        rep_count++;
        if (exp_rep.size() == 0) begin
          check("report_unexpected_step", res_step, -1);
        end else begin
          r = exp_rep.pop_front();
          check("res_step", res_step, r.step);
          check("res_err_count", res_err_count, r.err);
          check("res_first_err", res_first_err, r.first);
          check("res_status", res_status, r.status);
        end
      end
      if (step_req) step_cnt++;
      if (done) done_cnt++;
      if (chk_dut_en_next) begin
        check("dut_en_after_lock_loss", dut_en, 0);
        chk_dut_en_next = 1'b0;
      end
      if (lock_check_en && prev_lock && !mmcm_lock) begin
        check("dut_en_at_lock_drop", dut_en, 1);
        chk_dut_en_next = 1'b1;
      end
    end
    prev_lock = mmcm_lock;
  end

  task automatic run_sweep(input int ns, input int budget);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    num_steps = SW'(ns);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    check("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dut_en"}, dut_en, 0);
    check({tag, "_fifo_clear"}, fifo_clear, 0);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_step_req"}, step_req, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_bram_write_en"}, bram_write_en, 0);
    check({tag, "_bram_addr"}, bram_address_write, 0);
    check({tag, "_bram_din"}, bram_din, 0);
    check({tag, "_gold_addr"}, gold_addr, 0);
    check({tag, "_res_err_count"}, res_err_count, 0);
    check({tag, "_res_first_err"}, res_first_err, 0);
    check({tag, "_res_status"}, res_status, 0);
    check({tag, "_res_step"}, res_step, 0);
  endtask

  initial begin
    int s0, r0, d;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Golden match
    wr_count = 0; s0 = step_cnt; r0 = rep_count;
    exp_rep.push_back('{0, 0, 0, 0});
    run_sweep(1, 400);
    check("golden_writes", wr_count, 16);
    check("golden_reports", rep_count - r0, 1);
    check("golden_step_req", step_cnt - s0, 0);

    // Injected mismatches at samples 5 and 9
    corrupt_mask = 16'h0220;
    wr_count = 0;
    exp_rep.push_back('{0, 2, 5, 0});
    run_sweep(1, 400);
    check("inject_writes", wr_count, 16);
    repeat (5) @(negedge clk);
    check("inject_hold_err", res_err_count, 2);
    check("inject_hold_first", res_first_err, 5);
    corrupt_mask = '0;

    // Three-step sweep
    wr_count = 0; s0 = step_cnt; r0 = rep_count;
    exp_rep.push_back('{0, 0, 0, 0});
    exp_rep.push_back('{1, 0, 0, 0});
    exp_rep.push_back('{2, 0, 0, 0});
    run_sweep(3, 1500);
    check("sweep3_reports", rep_count - r0, 3);
    check("sweep3_step_req", step_cnt - s0, 2);
    check("sweep3_writes", wr_count, 48);

    // Stalled FIFO
    prod_limit = 4;
    wr_count = 0;
    exp_rep.push_back('{0, 0, 0, 1});
    run_sweep(1, 600);
    check("stall_writes", wr_count, 4);
    d = rv_cyc - last_rd_cyc;
    vectors++;
    if (d < TO + 2 || d > TO + 4) begin
      miscompares++;
      $display("FAIL stall_report_latency: got %0d cycles, expected %0d..%0d", d, TO + 2, TO + 4);
    end
    prod_limit = NS;

    // Lock loss after sample 7
    wr_count = 0;
    kill_at = 7;
    lock_check_en = 1'b1;
    exp_rep.push_back('{0, 0, 0, 2});
    run_sweep(1, 600);
    check("lock_writes_le8", (wr_count <= 8) ? 1 : 0, 1);
    check("lock_writes_ge1", (wr_count >= 1) ? 1 : 0, 1);
    lock_check_en = 1'b0;
    kill_at = -1;
    repeat (3) @(negedge clk);
    check("lock_restored", mmcm_lock, 1);

    // Saturating error count
    corrupt_mask = '1;
    wr_count = 0;
    exp_rep.push_back('{0, 7, 0, 0});
    run_sweep(1, 400);
    check("sat_writes", wr_count, 16);
    corrupt_mask = '0;

    // Asynchronous reset mid-RUN
    wr_count = 0;
    @(negedge clk);
    num_steps = SW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && wr_count < 3; i++) @(negedge clk);
    check("rst_reached_run", dut_en, 1);
    #2 nrst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // num_steps = 0 runs one step
    wr_count = 0; s0 = step_cnt; r0 = rep_count;
    exp_rep.push_back('{0, 0, 0, 0});
    run_sweep(0, 400);
    check("zero_steps_reports", rep_count - r0, 1);
    check("zero_steps_step_req", step_cnt - s0, 0);
    check("zero_steps_writes", wr_count, 16);

    check("reports_pending", exp_rep.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sweep_capture_ctrl.md
# sweep_capture_ctrl

Parametrised successor to the overclocking platform's capture control, run entirely in the reference clock domain. Over N frequency steps it clears the async FIFO, waits for MMCM lock, enables the DUT, and drains SAMPLES results into the output BRAM. While capturing, it compares each result against a golden ROM and produces a per-step error report. Between steps it requests the next MMCM frequency, so a full sweep runs without VIO interaction.

## Interface
- AddrWL, 11: BRAM/ROM address width.
- DataW, 18: DUT result width.
- StepW, 5: frequency-step index width.
- SAMPLES, 2**AddrWL: results captured per step; legal range 1..2**AddrWL.
- CLR_CYC, 8: cycles `fifo_clear` is held high.
- TIMEOUT, 4096: idle cycles allowed in RUN before the step is aborted.
- ErrW, AddrWL+1: error counter width.

Ports:
- clk  in  1  reference clock (200 MHz); the only clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- num_steps  in  StepW  steps per sweep; latched at start; 0 is treated as 1.
- mmcm_lock  in  1  MMCM lock, already synchronous to clk.
- step_req  out  1  one-cycle pulse requesting the next MMCM frequency.
- dut_en  out  1  DUT enable.
- fifo_clear  out  1  FIFO reset.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read; standard mode, dout valid the next cycle.
- fifo_dout  in  DataW  FIFO data.
- bram_write_en  out  1  BRAM write enable.
- bram_address_write  out  AddrWL  BRAM write address.
- bram_din  out  DataW  BRAM write data.
- gold_addr  out  AddrWL  golden ROM address; ROM is synchronous with 1-cycle latency.
- gold_data  in  DataW  golden ROM data.
- res_valid  out  1  one-cycle pulse when a step report is ready.
- res_step  out  StepW  index of the reported step.
- res_err_count  out  ErrW  mismatches in the reported step; saturating.
- res_first_err  out  AddrWL  address of the first mismatch; 0 if there was none.
- res_status  out  2  00 ok, 01 timeout, 10 lock lost.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at sweep end.

## Operation
- All outputs reset to 0, and the FSM resets to IDLE.
- **IDLE:** on `start`, latch `num_steps`, set step=0, go to CLEAR.
- **CLEAR:** hold `fifo_clear`=1 for CLR_CYC cycles with `dut_en`=0. Reset the sample counter, read counter, error counter and first-error register. Go to LOCK_WAIT.
- **LOCK_WAIT:** stay until `mmcm_lock`=1, then go to RUN.
- **RUN:**
  - `dut_en`=1.
  - `fifo_rd_en` = !`fifo_empty` && (reads issued < SAMPLES).
  - `gold_addr` = read count, driven in the same cycle as `fifo_rd_en`.
  - Exit when SAMPLES writes complete.
  - If `mmcm_lock` drops, exit with status 10.
  - If TIMEOUT consecutive cycles pass with no read, exit with status 01.
- **FLUSH:** `dut_en`=0; wait 2 cycles for in-flight compare/write to retire, then go to REPORT.
- **REPORT:** pulse `res_valid` with `res_*` registered, then go to STEP or DONE.
- **STEP:** only when step+1 < num_steps. Pulse `step_req`, wait for `mmcm_lock`=0, increment step, go to CLEAR. CLEAR then LOCK_WAIT covers relock.
- **DONE:** pulse `done`, go to IDLE.
- Compare: a mismatch (fifo_dout != gold_data) increments the error count, saturating at 2**ErrW-1. The first mismatch in a step also records its write address.
- `res_*` outputs hold their values until the next REPORT.
- `start` during busy is ignored.
- An aborted step still writes the samples already read. Samples read before an abort still complete their compare and write.

## Timing
- `fifo_rd_en` at cycle t → at t+1: `bram_write_en`=1, `bram_address_write` = sample index, `bram_din` = `fifo_dout`, compare evaluated. `res_err_count` updates at t+2.
- Back-to-back reads are allowed, giving 1 sample per cycle when the FIFO is non-empty.
- `res_valid` follows the last BRAM write by at least 2 cycles.
- `step_req` is exactly 1 cycle.
- The TIMEOUT counter resets on every read and on entry to RUN.
- Asynchronous reset mid-sweep returns to IDLE immediately. `dut_en`, `fifo_clear` and all strobes go to 0.

## Test plan
- **Golden match:** SAMPLES=16, num_steps=1, FIFO data equals ROM → 16 writes at addresses 0..15, res_err_count=0, res_status=00, then `done`.
- **Injected mismatches:** corrupt samples 5 and 9 → res_err_count=2, res_first_err=5.
- **Three-step sweep:** num_steps=3, lock drops and rises after each `step_req` → 3 `res_valid` pulses with res_step 0,1,2; exactly 2 `step_req` pulses.
- **Stalled FIFO:** FIFO empty after 4 samples, TIMEOUT=64 → res_status=01, 4 writes, report 64+FLUSH cycles after the last read.
- **Lock loss:** `mmcm_lock` drops at sample 7 → res_status=10, `dut_en` low the next cycle, ≤8 writes.
- **Saturation and reset:** ErrW=3 with all 16 samples mismatching → res_err_count=7. Reset asserted mid-RUN → `busy`=0 and all outputs 0; `start` in IDLE with num_steps=0 → one step.
